// File: rtl/ceres_param.sv
// ============================================================================
// Module      : ceres_param
// Description : Shared fetch-side constants and request/response structs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ceres_param;

   localparam int XLEN      = 32;
   localparam int BLK_SIZE  = 128;
   localparam int BLK_BYTES = BLK_SIZE / 8;
   localparam int OFF_W     = $clog2(BLK_BYTES);
   localparam int LINE_W    = XLEN - OFF_W;

   typedef struct packed {
      logic            valid;
      logic            ready;
      logic [XLEN-1:0] addr;
      logic            uncached;
   } abuff_req_t;

   typedef struct packed {
      logic        valid;
      logic        ready;
      logic [31:0] blk;
      logic        waiting_second;
   } abuff_res_t;

   typedef struct packed {
      logic                valid;
      logic                ready;
      logic [BLK_SIZE-1:0] blk;
   } blowX_res_t;

   typedef struct packed {
      logic            valid;
      logic            ready;
      logic [XLEN-1:0] addr;
      logic            uncached;
   } icache_req_t;

endpackage

`default_nettype wire

// File: rtl/abuff_line_bank.sv
// ============================================================================
// Module      : abuff_line_bank
// Description : One cache-line slot: valid/tag/data with write port and hit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module abuff_line_bank
   import ceres_param::*;
(
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clear_i,
   input  logic                we_i,
   input  logic [LINE_W-1:0]   wtag_i,
   input  logic [BLK_SIZE-1:0] wdata_i,
   input  logic [LINE_W-1:0]   tag_i,
   output logic                hit_o,
   output logic [BLK_SIZE-1:0] data_o
);

   logic                r_valid;
   logic [LINE_W-1:0]   r_tag;
   logic [BLK_SIZE-1:0] r_data;

   // Clear wins over a simultaneous write so a flushed fill never lands.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid <= 1'b0;
         r_tag   <= '0;
         r_data  <= '0;
      end else if (clear_i) begin
         r_valid <= 1'b0;
      end else if (we_i) begin
         r_valid <= 1'b1;
         r_tag   <= wtag_i;
         r_data  <= wdata_i;
      end
   end

   assign hit_o  = r_valid && (r_tag == tag_i);
   assign data_o = r_data;

endmodule

`default_nettype wire

// File: rtl/instr_align_buffer.sv
// ============================================================================
// Module      : instr_align_buffer
// Description : Two-line fetch alignment buffer returning a 32-bit halfword-
//               aligned window, including windows straddling two lines.
//               Define ALIGN_BUF_ASSERT_EN to compile in protocol assertions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_align_buffer
   import ceres_param::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        flush_i,
   input  abuff_req_t  buff_req_i,
   output abuff_res_t  buff_res_o,
   input  blowX_res_t  lowX_res_i,
   output icache_req_t lowX_req_o
);

   logic [LINE_W-1:0]     w_line;
   logic [LINE_W-1:0]     w_line_n;
   logic [OFF_W-1:0]      w_off;
   logic [LINE_W-1:0]     w_lookup [2];
   logic                  w_hit    [2];
   logic [BLK_SIZE-1:0]   w_data   [2];
   logic                  w_hit_l;
   logic                  w_hit_n;
   logic [2*BLK_SIZE-1:0] w_pair;
   logic [2*BLK_SIZE-1:0] w_shifted;
   logic [31:0]           w_window;
   logic                  w_cross;
   logic                  w_compressed;
   logic                  w_need_n;
   logic                  w_miss;
   logic [LINE_W-1:0]     w_miss_line;
   logic                  w_fill;

   logic                  r_pending;
   logic [LINE_W-1:0]     r_line;
   logic                  r_filled;
   logic [LINE_W-1:0]     r_fill_line;

   assign w_line   = buff_req_i.addr[XLEN-1:OFF_W];
   assign w_line_n = w_line + LINE_W'(1);
   assign w_off    = buff_req_i.addr[OFF_W-1:0];

   // Lines L and L+1 always map to opposite banks, so each bank sees one tag.
   assign w_lookup[0] = w_line[0] ? w_line_n : w_line;
   assign w_lookup[1] = w_line[0] ? w_line   : w_line_n;

   assign w_fill = lowX_res_i.valid && r_pending && !flush_i;

   generate
      for (genvar b = 0; b < 2; b++) begin : g_bank
         abuff_line_bank u_bank (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .clear_i (flush_i),
            .we_i    (w_fill && (r_line[0] == 1'(b))),
            .wtag_i  (r_line),
            .wdata_i (lowX_res_i.blk),
            .tag_i   (w_lookup[b]),
            .hit_o   (w_hit[b]),
            .data_o  (w_data[b])
         );
      end
   endgenerate

   always_comb begin
      w_hit_l      = w_hit[w_line[0]];
      w_hit_n      = w_hit[~w_line[0]];
      w_pair       = {w_data[~w_line[0]], w_data[w_line[0]]};
      w_shifted    = w_pair >> {w_off, 3'b000};
      w_window     = w_shifted[31:0];
      w_cross      = w_off > OFF_W'(BLK_BYTES - 4);
      w_compressed = w_window[1:0] != 2'b11;
      w_need_n     = w_cross && !w_compressed;
      w_miss       = !w_hit_l || (w_need_n && !w_hit_n);
      w_miss_line  = w_hit_l ? w_line_n : w_line;
   end

   always_comb begin
      buff_res_o       = '0;
      buff_res_o.valid = buff_req_i.valid && !w_miss;
      buff_res_o.ready = !r_pending;
      buff_res_o.blk   = (w_cross && w_compressed) ? {16'h0000, w_window[15:0]}
                                                   : w_window;
      // Line L just landed for a full-width straddle and L+1 is still absent.
      buff_res_o.waiting_second = r_filled && buff_req_i.valid &&
                                  (r_fill_line == w_line) && w_hit_l &&
                                  w_need_n && !w_hit_n;

      lowX_req_o          = '0;
      lowX_req_o.valid    = buff_req_i.valid && buff_req_i.ready && w_miss && !r_pending;
      lowX_req_o.ready    = 1'b1;
      lowX_req_o.addr     = {w_miss_line, {OFF_W{1'b0}}};
      lowX_req_o.uncached = buff_req_i.uncached;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_pending   <= 1'b0;
         r_line      <= '0;
         r_filled    <= 1'b0;
         r_fill_line <= '0;
      end else begin
         r_filled    <= w_fill;
         r_fill_line <= r_line;
         if (flush_i || w_fill) begin
            r_pending <= 1'b0;
         end else if (lowX_req_o.valid && lowX_res_i.ready) begin
            r_pending <= 1'b1;
            r_line    <= w_miss_line;
         end
      end
   end

`ifdef ALIGN_BUF_ASSERT_EN
   a_no_req_pending : assert property (@(posedge clk_i) disable iff (!rst_ni)
      r_pending |-> !lowX_req_o.valid);
   a_even_addr : assert property (@(posedge clk_i) disable iff (!rst_ni)
      buff_res_o.valid |-> !buff_req_i.addr[0]);
   a_ws_pulse : assert property (@(posedge clk_i) disable iff (!rst_ni)
      buff_res_o.waiting_second |=> !buff_res_o.waiting_second);
`else
   // No runtime checks in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_align_buffer.sv
// ============================================================================
// Module      : tb_instr_align_buffer
// Description : Scoreboard bench for instr_align_buffer with an icache model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_align_buffer;
   import ceres_param::*;

   logic        clk;
   logic        rst_n;
   logic        flush;
   abuff_req_t  req;
   abuff_res_t  res;
   blowX_res_t  low_res;
   icache_req_t low_req;

   int n_chk  = 0;
   int n_pass = 0;

   logic [31:0]  sb [$];
   logic [127:0] mem [logic [27:0]];
   logic         mb_v [2];
   logic [27:0]  mb_t [2];

   instr_align_buffer dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .flush_i    (flush),
      .buff_req_i (req),
      .buff_res_o (res),
      .lowX_res_i (low_res),
      .lowX_req_o (low_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [127:0] get_line(input logic [27:0] l);
      logic [127:0] d;
      if (mem.exists(l)) return mem[l];
      for (int w = 0; w < 4; w++)
         d[w*32 +: 32] = (32'h9E37_79B9 * (32'(l) * 32'd4 + 32'(w) + 32'd1)) | 32'h0003_0003;
      return d;
   endfunction

   function automatic logic [31:0] raw_window(input logic [31:0] a);
      logic [255:0] both;
      logic [31:0]  w;
      int           off;
      both = {get_line(a[31:4] + 28'd1), get_line(a[31:4])};
      off  = int'(a[3:0]);
      for (int i = 0; i < 4; i++) w[i*8 +: 8] = both[(off + i)*8 +: 8];
      return w;
   endfunction

   function automatic bit need_second(input logic [31:0] a);
      logic [31:0] w;
      w = raw_window(a);
      return (a[3:0] > 4'd12) && (w[1:0] == 2'b11);
   endfunction

   function automatic logic [31:0] exp_window(input logic [31:0] a);
      logic [31:0] w;
      w = raw_window(a);
      if ((a[3:0] > 4'd12) && (w[1:0] != 2'b11)) w[31:16] = 16'h0000;
      return w;
   endfunction

   function automatic bit hit_m(input logic [27:0] l);
      return mb_v[l[0]] && (mb_t[l[0]] == l);
   endfunction

   task automatic clear_model();
      mb_v[0] = 1'b0;
      mb_v[1] = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      clear_model();
   endtask

   // Drive one fetch, answering lower requests from the icache model.
   task automatic fetch(input logic [31:0] a, input int exp_reqs,
                        input logic rdy = 1'b1, input logic unc = 1'b0);
      logic [27:0] l, ln, rl;
      bit          nn, done, jf, ews;
      int          reqs, since;
      l = a[31:4]; ln = l + 28'd1; nn = need_second(a);
      done = 0; jf = 0; ews = 0; reqs = 0; since = 0;
      sb.push_back(exp_window(a));
      req.valid = 1'b1; req.ready = rdy; req.addr = a; req.uncached = unc;
      for (int c = 0; c < 30 && !done; c++) begin
         @(negedge clk);
         since++;
         if (jf) begin
            chk("waiting_second", 32'(res.waiting_second), 32'(ews));
            jf = 0;
         end
         if (res.valid) begin
            chk("blk", res.blk, sb.pop_front());
            chk("lower_reqs", 32'(reqs), 32'(exp_reqs));
            if (reqs > 0) chk("fill_latency", 32'(since), 32'd1);
            done = 1;
         end else if (low_req.valid) begin
            rl = hit_m(l) ? ln : l;
            chk("req_addr", low_req.addr, {rl, 4'h0});
            chk("req_uncached", 32'(low_req.uncached), 32'(unc));
            reqs++;
            @(posedge clk); #1;
            chk("ready_pending", 32'(res.ready), 32'd0);
            low_res.valid = 1'b1;
            low_res.blk   = get_line(rl);
            @(posedge clk); #1;
            low_res.valid = 1'b0;
            mb_v[rl[0]] = 1'b1;
            mb_t[rl[0]] = rl;
            ews   = (rl == l) && nn && !hit_m(ln);
            jf    = 1;
            since = 0;
         end
      end
      chk("fetch_done", 32'(done), 32'd1);
      if (!done) void'(sb.pop_front());
      req.valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_valid"}, 32'(res.valid), 32'd0);
      chk({tag, "_ready"}, 32'(res.ready), 32'd1);
      chk({tag, "_ws"},    32'(res.waiting_second), 32'd0);
      chk({tag, "_lreq"},  32'(low_req.valid), 32'd0);
   endtask

   initial begin
      logic [127:0] tmp;
      rst_n = 1'b0; flush = 1'b0;
      req = '0; low_res = '0;
      low_res.ready = 1'b1;
      clear_model();
      mem[28'h800_0000] = {32'hAB03_1234, 32'h5566_7788, 32'h99AA_BBCC, 32'h0000_0013};

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Cold miss (uncached), then same-line hit.
      fetch(32'h8000_0000, 1, 1'b1, 1'b1);
      fetch(32'h8000_0006, 0);

      // Lower requests suppressed when not ready; hits still served.
      req.valid = 1'b1; req.ready = 1'b0; req.addr = 32'h8000_0060; req.uncached = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("norq_lreq",  32'(low_req.valid), 32'd0);
         chk("norq_valid", 32'(res.valid), 32'd0);
      end
      @(posedge clk); #1;
      req.valid = 1'b0;
      fetch(32'h8000_0008, 0, 1'b0);

      // Straddle with line L resident: only L+1 requested.
      fetch(32'h8000_000E, 1);

      // Straddle double miss: L, waiting_second, then L+1.
      do_flush();
      fetch(32'h8000_000E, 2);

      // Compressed straddle needs only line L.
      do_flush();
      tmp = mem[28'h800_0000];
      tmp[127:112] = 16'h4501;
      mem[28'h800_0000] = tmp;
      fetch(32'h8000_000E, 1);
      chk("compressed_blk_const", res.blk, 32'h0000_4501);

      // Flush while pending; stale fill must be dropped.
      req.valid = 1'b1; req.ready = 1'b1; req.addr = 32'h8000_0040;
      @(negedge clk);
      chk("flp_lreq", 32'(low_req.valid), 32'd1);
      @(posedge clk); #1;
      chk("flp_pending", 32'(res.ready), 32'd0);
      req.valid = 1'b0;
      do_flush();
      chk("flp_ready", 32'(res.ready), 32'd1);
      low_res.valid = 1'b1; low_res.blk = get_line(28'h800_0004);
      @(posedge clk); #1;
      low_res.valid = 1'b0;
      fetch(32'h8000_0040, 1);

      // Asynchronous reset in the middle of a miss.
      req.valid = 1'b1; req.addr = 32'h8000_0050;
      @(negedge clk);
      chk("rst_lreq", 32'(low_req.valid), 32'd1);
      @(posedge clk); #1;
      chk("rst_pending", 32'(res.ready), 32'd0);
      #2;
      rst_n = 1'b0;
      req.valid = 1'b0;
      #1;
      check_idle("async_rst");
      clear_model();
      @(posedge clk); #1;
      rst_n = 1'b1;
      fetch(32'h8000_0050, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/instr_align_buffer.md
# instr_align_buffer

Fetch-side alignment buffer between the PC and the instruction cache. It returns a 32-bit, halfword-aligned instruction window for any fetch address, including windows that straddle two cache lines. It holds two recently filled lines and issues line requests to the icache on a miss. Its output feeds the compressed decoder in the fetch stage.

## Interface
Parameters:
- XLEN, 32, address/instruction width
- BLK_SIZE, 128, cache line width in bits; BLK_BYTES = BLK_SIZE/8

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  invalidate buffer, drop outstanding request
- buff_req_i  in  abuff_req_t  fields:
  - valid: fetch request
  - ready: new lower requests allowed
  - addr[XLEN]
  - uncached
- buff_res_o  out  abuff_res_t  fields:
  - valid: blk is usable this cycle
  - ready: no request outstanding
  - blk[32]
  - waiting_second
- lowX_res_i  in  blowX_res_t  fields:
  - valid
  - ready: cache accepts request
  - blk[BLK_SIZE]
- lowX_req_o  out  icache_req_t  fields:
  - valid
  - ready: tied 1
  - addr: line-aligned
  - uncached

## Operation
- Address decode:
  - line L = addr >> log2(BLK_BYTES)
  - off = addr mod BLK_BYTES
- Storage: two banks, selected by L[0]. Each bank holds valid, tag (L), and data. Lines L and L+1 always sit in different banks.
- hitX is true when bank[X[0]] is valid and its tag equals X.
- Window extraction, little-endian:
  - off ≤ BLK_BYTES-4: blk = bytes off..off+3 of line L.
  - off = BLK_BYTES-2 (straddle): blk[15:0] = line L top halfword; blk[31:16] = line L+1 bits [15:0].
  - Straddle where the low halfword bits[1:0] ≠ 2'b11 (compressed): only line L is needed, and blk[31:16] = 0.
- buff_res_o.valid is combinational: buff_req_i.valid && all needed lines hit. It asserts in the same cycle as the request.
- Miss issue:
  - lowX_req_o.valid = buff_req_i.valid && buff_req_i.ready && a needed line misses && no request outstanding.
  - lowX_req_o.addr = first missing line (L before L+1), left-shifted to byte address.
  - lowX_req_o.uncached = buff_req_i.uncached.
- Outstanding request:
  - Captured (addr, pending=1) when lowX_req_o.valid && lowX_res_i.ready.
  - On lowX_res_i.valid && pending, the captured line is written to its bank and pending clears.
  - A fill arriving with pending=0 is discarded.
- waiting_second is a one-cycle pulse, asserted in the cycle after a fill of line L for a straddling, non-compressed request while line L+1 still misses.
- buff_res_o.ready = !pending.
- flush_i: all banks invalid and pending=0 at the next edge. flush_i has priority over a fill arriving in the same cycle. Outputs during flush follow the normal combinational rules; the fetch stage masks them.
- buff_req_i.ready=0 suppresses new lower requests only. Hits still respond.
- Uncached fills allocate like cached ones and are removed only by flush or replacement.

## Timing
- Reset values: banks invalid, pending 0, buff_res_o.valid 0, waiting_second 0, lowX_req_o.valid 0, buff_res_o.ready 1.
- Hit: 0-cycle latency (combinational).
- Single-line miss:
  - Request in cycle t.
  - Fill in cycle f.
  - buff_res_o.valid in cycle f+1.
- Double miss:
  - Fill of L in cycle f.
  - waiting_second in cycle f+1, when the request for L+1 is issued.
  - Valid one cycle after the L+1 fill.
- A fill and a flush in the same cycle: the flush wins and the line is not written.
- An address change while pending: the old fill still lands in its bank. New misses wait for pending to clear.

## Configuration
- ALIGN_BUF_ASSERT_EN defined: the following assertions are compiled in:
  - no lowX_req_o.valid while pending;
  - addr[0]==0 whenever buff_res_o.valid;
  - waiting_second never held for 2 cycles.
- Undefined: no assertions; functionality is identical.

## Structure
- Shared package ceres_param holds:
  - constants XLEN, BLK_SIZE;
  - typedefs abuff_req_t, abuff_res_t, blowX_res_t, icache_req_t.
- One natural sub-module: abuff_line_bank (valid/tag/data register with write port and hit compare), instantiated twice.

## Test plan
All scenarios use BLK_SIZE=128.
- Cold request at addr 0x8000_0000 → lowX_req_o.valid=1 with addr 0x8000_0000. After the fill with word0 = 0x00000013, the next cycle gives valid=1 and blk=0x00000013.
- Hit with line 0x80000000 resident, addr 0x8000_0006 → same-cycle valid=1, blk = bytes 6..9.
- Straddle at addr 0x8000_000E with line 0x80000010 absent and the top halfword ending in 2'b11:
  - request for 0x8000_0010, then waiting_second only if line 0x80000000 was also just filled;
  - after the fill, blk = {line1[15:0], line0[127:112]}.
- Compressed straddle at addr 0x8000_000E with a top halfword of 0x4501 (bits[1:0]=01) → valid with only line 0 present, blk=0x00004501, and no lower request.
- Flush while pending, then a stale fill arrives → the fill is discarded, banks stay invalid, and the next request misses again.
- Reset asserted mid-miss → all outputs return to their reset values immediately (asynchronous). After release, the first request re-issues the line fetch.
